// File: rtl/fifo_stream_out.sv
// Adapts a 1-cycle-latency synchronous FIFO read port to a valid/ready stream
// through a 2-entry skid buffer, with flush and a wrapping delivered-beat counter.
module fifo_stream_out #(
  parameter int DATA_WIDTH = 8,
  parameter int BEAT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam logic [BEAT_CNT_W-1:0] BEAT_ONE = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [1:0]            level_r;
  logic                  inflight_r;
  logic                  valid_r;
  logic [BEAT_CNT_W-1:0] beat_r;

  logic                  pop_s;
  logic                  rd_en_s;
  logic [2:0]            occ_s;
  logic [1:0]            lvl_after_pop_s;
  logic [1:0]            level_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0] tail_s;

  // Read issue: occupancy counts buffered words plus the one still in flight.
  always_comb begin
    pop_s   = valid_r && m_ready;
    occ_s   = {1'b0, level_r} + {2'b00, inflight_r};
    rd_en_s = 1'b0;
    if (rst || flush || fifo_empty) begin
      rd_en_s = 1'b0;
    end else if (occ_s < 3'd2) begin
      rd_en_s = 1'b1;
    end else if ((occ_s == 3'd2) && pop_s) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Buffer next state: pop shifts tail to head, then an arrival fills the next free slot.
  always_comb begin
    head_s          = head_r;
    tail_s          = tail_r;
    lvl_after_pop_s = level_r;
    if (pop_s) begin
      head_s          = tail_r;
      lvl_after_pop_s = level_r - 2'd1;
    end else begin
      head_s          = head_r;
      lvl_after_pop_s = level_r;
    end
    if (inflight_r) begin
      case (lvl_after_pop_s)
        2'd0:    head_s = fifo_dout;
        2'd1:    tail_s = fifo_dout;
        default: tail_s = tail_r;
      endcase
    end else begin
      tail_s = tail_r;
    end
    level_s = lvl_after_pop_s + {1'b0, inflight_r};
  end

  // State registers; reset outranks flush, and flush still counts a coinciding pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= {DATA_WIDTH{1'b0}};
      tail_r     <= {DATA_WIDTH{1'b0}};
      level_r    <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      beat_r     <= {BEAT_CNT_W{1'b0}};
    end else if (flush) begin
      head_r     <= head_r;
      tail_r     <= tail_r;
      level_r    <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      beat_r     <= pop_s ? (beat_r + BEAT_ONE) : beat_r;
    end else begin
      head_r     <= head_s;
      tail_r     <= tail_s;
      level_r    <= level_s;
      inflight_r <= rd_en_s;
      valid_r    <= (level_s != 2'd0);
      beat_r     <= pop_s ? (beat_r + BEAT_ONE) : beat_r;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = valid_r;
  assign m_data     = head_r;
  assign level      = level_r;
  assign beat_cnt   = beat_r;

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of each data word.
REQ-002 Parameter: BEAT_CNT_W, default 16, width of the delivered-beat counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-006 fifo_empty  input  1  empty flag from the upstream synchronous FIFO.
REQ-007 fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-008 fifo_dout  input  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after a cycle with fifo_rd_en=1.
REQ-009 m_valid  output  1  downstream stream valid.
REQ-010 m_ready  input  1  downstream stream ready.
REQ-011 m_data  output  DATA_WIDTH  downstream stream data.
REQ-012 level  output  2  number of words held in the skid buffer (0..2).
REQ-013 beat_cnt  output  BEAT_CNT_W  count of completed downstream transfers.

Function
REQ-014 The block SHALL convert the FIFO rd_en/dout interface (1-cycle read latency) into a valid/ready stream with in-order delivery, no loss and no duplication.
REQ-015 Storage SHALL be a 2-entry buffer (head, tail) plus a 1-bit in-flight flag marking a read issued in the previous cycle.
REQ-016 pop SHALL be defined as m_valid && m_ready; a transfer completes on each clock edge where pop=1.
REQ-017 fifo_rd_en SHALL be combinational: !rst && !flush && !fifo_empty && ((level + inflight) < 2 || ((level + inflight) == 2 && pop)).
REQ-018 inflight SHALL register fifo_rd_en each cycle; when inflight=1, fifo_dout SHALL be written to the buffer at the next free position after any same-cycle pop.
REQ-019 m_valid SHALL equal (level != 0); m_data SHALL equal the head entry; both SHALL be driven from registers, with no combinational path from fifo_dout or m_ready.
REQ-020 Once m_valid is asserted, m_valid and m_data SHALL stay stable until pop.
REQ-021 level SHALL update as level + (inflight ? 1 : 0) - (pop ? 1 : 0) and SHALL never exceed 2.
REQ-022 Simultaneous pop and arrival at level=1: the arriving word SHALL become the head and level SHALL remain 1.
REQ-023 Simultaneous pop and arrival at level=2: the tail SHALL shift to the head, the arriving word SHALL become the tail, and level SHALL remain 2.
REQ-024 Steady state with fifo_empty=0 and m_ready=1 SHALL sustain 1 transfer per cycle after a first-word latency of 2 cycles (rd_en at cycle 0, m_valid at cycle 2).
REQ-025 beat_cnt SHALL increment by 1 on each pop and wrap from 2^BEAT_CNT_W-1 to 0.
REQ-026 A flush cycle SHALL clear level to 0 and force fifo_rd_en=0.
REQ-027 A word arriving from a read issued in the cycle before flush SHALL be discarded.
REQ-028 A pop coinciding with flush SHALL count in beat_cnt.
REQ-029 When fifo_empty=1, fifo_rd_en SHALL stay 0; the block SHALL never read an empty FIFO.

Reset
REQ-030 On a clock edge with rst=1: level=0, inflight=0, m_valid=0, m_data=0, and beat_cnt=0.
REQ-031 fifo_rd_en SHALL be 0 in every cycle where rst=1.
REQ-032 A word in flight when rst asserts SHALL be discarded.
REQ-033 Reset SHALL take priority over flush and over all data movement.

Verification
REQ-034 Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 -> m_data 0x01..0x10 on 16 consecutive cycles starting 2 cycles after the first rd_en; beat_cnt=16.
REQ-035 Backpressure: 4 words loaded, m_ready=0 for 10 cycles -> level=2, exactly 2 reads issued, m_data=0x01 held stable; then m_ready=1 -> 0x01..0x04 delivered in order.
REQ-036 Random m_ready (50%) with 64 random words -> output sequence matches the scoreboard; level<=2 at all times; fifo_rd_en never 1 while fifo_empty=1.
REQ-037 Flush with level=2 and a read in flight -> next cycle level=0 and m_valid=0, the in-flight word is dropped, and the following word delivered is the next FIFO entry.
REQ-038 rst asserted for 1 cycle mid-stream with beat_cnt=5 -> beat_cnt=0, m_valid=0 and fifo_rd_en=0 in the rst cycle.
REQ-039 beat_cnt with BEAT_CNT_W=4 -> after 17 pops beat_cnt=1.
